// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch PC sequencer.
//   mux_types_pkg     : pcMux, the next-PC source select (PC_SEQ, PC_BR, PC_JR, PC_J)
//   cpu_types_pkg     : pcseq_state_t, the sequencer FSM states
//   pc_sequencer_pkg  : perf counter width, saturating increment, flush decode
package mux_types_pkg;
  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JR  = 2'd2,
    PC_J   = 2'd3
  } pcMux;
endpackage

package cpu_types_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    DRAIN      = 2'd2,
    HALTED     = 2'd3
  } pcseq_state_t;
endpackage

package pc_sequencer_pkg;
  import mux_types_pkg::*;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

  // {flush_ifid, flush_idex} for an applied redirect. A taken branch resolves
  // in EX, so both younger instructions (IF/ID and ID/EX) are wrong-path;
  // jumps resolve in ID and only kill the instruction behind them.
  function automatic logic [1:0] flush_of(input pcMux s);
    case (s)
      PC_BR:       return 2'b11;
      PC_JR, PC_J: return 2'b10;
      default:     return 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: hazard/cache status in, PC and pipeline-register controls out.
//   master : the sequencer (reads status, drives pcEN/pcSel/stall/flush/halt)
//   slave  : the datapath side (drives status, consumes controls)
interface pc_sequencer_if;
  import mux_types_pkg::*;

  logic ihit, dmem_req, dhit, lu_hazard, br_taken_ex, jr_id, j_id, halt_id;
  logic pcEN;
  pcMux pcSel;
  logic stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex;
  logic redirect_pend, halt;

  modport master (
    input  ihit, dmem_req, dhit, lu_hazard, br_taken_ex, jr_id, j_id, halt_id,
    output pcEN, pcSel, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           redirect_pend, halt
  );

  modport slave (
    output ihit, dmem_req, dhit, lu_hazard, br_taken_ex, jr_id, j_id, halt_id,
    input  pcEN, pcSel, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
           redirect_pend, halt
  );
endinterface

// File: rtl/redirect_prio.sv
// redirect_prio: combinational priority encoder for PC redirects.
//   br_taken_ex, jr_id, j_id : redirect requests (branch in EX beats ID jumps)
//   sel                      : winning pcMux source (PC_SEQ when none)
//   valid                    : any redirect requested
module redirect_prio
  import mux_types_pkg::*;
(
  input  logic br_taken_ex,
  input  logic jr_id,
  input  logic j_id,
  output pcMux sel,
  output logic valid
);
  always_comb begin
    sel = PC_SEQ;
    if (br_taken_ex) sel = PC_BR;
    else if (jr_id)  sel = PC_JR;
    else if (j_id)   sel = PC_J;
  end

  assign valid = br_taken_ex | jr_id | j_id;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: sole driver of the fetch PC enable/select, plus pipeline
// stall/flush controls and the halt drain sequence.
//   CLK, nRST : clock, asynchronous active-low reset (outputs forced idle while low)
//   sq        : pc_sequencer_if.master, status in / controls out
//   HALT_DRAIN: non-frozen cycles between HALT leaving ID and halt asserting
// Optional PC_SEQUENCER_PERF_EN adds stall_cycles, redirect_count, lu_bubbles
// (32-bit saturating counters).
module pc_sequencer
  import mux_types_pkg::*, cpu_types_pkg::*, pc_sequencer_pkg::*;
#(
  parameter int HALT_DRAIN = 3
) (
  input  logic CLK,
  input  logic nRST,
  pc_sequencer_if.master sq
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] redirect_count,
  output logic [PERF_W-1:0] lu_bubbles
`endif
);
  localparam int CW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN + 1) : 1;

  pcseq_state_t state, state_n;
  pcMux         pend, pend_n, rsel, sel_eff, pcsel;
  logic [CW-1:0] cnt, cnt_n;
  logic freeze, rvld, pcen, stalls, fl_ifid, fl_idex, rpend, hlt;

  assign freeze = (sq.dmem_req & ~sq.dhit) | ~sq.ihit;

  redirect_prio u_prio (
    .br_taken_ex (sq.br_taken_ex),
    .jr_id       (sq.jr_id),
    .j_id        (sq.j_id),
    .sel         (rsel),
    .valid       (rvld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      pend  <= PC_SEQ;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    cnt_n   = cnt;
    sel_eff = pend;
    pcen    = 1'b0;
    pcsel   = PC_SEQ;
    stalls  = 1'b0;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    rpend   = 1'b0;
    hlt     = 1'b0;
    unique case (state)
      RUN: begin
        if (freeze) begin
          stalls = 1'b1;
          pcsel  = rsel;
          if (rvld) begin
            // Pipeline is held, so the target stays valid; remember the source.
            pend_n  = rsel;
            rpend   = 1'b1;
            state_n = REDIR_WAIT;
          end
        end else if (rvld) begin
          pcsel              = rsel;
          pcen               = 1'b1;
          {fl_ifid, fl_idex} = flush_of(rsel);
        end else if (sq.lu_hazard) begin
          stalls  = 1'b0;
          fl_idex = 1'b1;
        end else if (sq.halt_id) begin
          fl_ifid = 1'b1;
          cnt_n   = CW'(HALT_DRAIN);
          state_n = DRAIN;
        end else begin
          pcen = 1'b1;
        end
      end
      REDIR_WAIT: begin
        rpend = 1'b1;
        // An EX branch is older than any pending ID jump and supersedes it.
        sel_eff = sq.br_taken_ex ? PC_BR : pend;
        pcsel   = sel_eff;
        if (freeze) begin
          stalls = 1'b1;
          pend_n = sel_eff;
        end else begin
          pcen               = 1'b1;
          {fl_ifid, fl_idex} = flush_of(sel_eff);
          pend_n             = PC_SEQ;
          state_n            = RUN;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          hlt     = 1'b1;
          state_n = HALTED;
        end
        if (freeze) begin
          stalls = 1'b1;
        end else begin
          fl_ifid = 1'b1;
          if (cnt != '0) cnt_n = cnt - CW'(1);
        end
      end
      HALTED: hlt = 1'b1;
    endcase
    // Reset is asynchronous: hold every control idle while it is asserted.
    if (!nRST) begin
      pcen    = 1'b0;
      pcsel   = PC_SEQ;
      stalls  = 1'b0;
      fl_ifid = 1'b0;
      fl_idex = 1'b0;
      rpend   = 1'b0;
      hlt     = 1'b0;
    end
  end

  // A load-use bubble is the only non-frozen case that stalls IF/ID.
  logic lu_stall;
  assign lu_stall = (state == RUN) & ~freeze & ~rvld & sq.lu_hazard & nRST;

  assign sq.pcEN          = pcen;
  assign sq.pcSel         = pcsel;
  assign sq.stall_ifid    = stalls | lu_stall;
  assign sq.stall_idex    = stalls;
  assign sq.stall_exmem   = stalls;
  assign sq.flush_ifid    = fl_ifid;
  assign sq.flush_idex    = fl_idex;
  assign sq.redirect_pend = rpend;
  assign sq.halt          = hlt;

`ifdef PC_SEQUENCER_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
      lu_bubbles     <= '0;
    end else begin
      stall_cycles   <= sat_inc(stall_cycles, freeze);
      redirect_count <= sat_inc(redirect_count, pcen && (pcsel != PC_SEQ));
      lu_bubbles     <= sat_inc(lu_bubbles, lu_stall);
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Stimulus rows: {nrst, ihit, dmem_req, dhit, lu_hazard, br, jr, j, halt_id}
// Expected rows: {pcEN, pcSel[1:0], stall_ifid, stall_idex, stall_exmem,
//                 flush_ifid, flush_idex, redirect_pend, halt}
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  pc_sequencer_if sq();

`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] stall_cycles, redirect_count, lu_bubbles;
  pc_sequencer #(.HALT_DRAIN(3)) dut (
    .CLK(clk), .nRST(nrst), .sq(sq),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count), .lu_bubbles(lu_bubbles)
  );
`else
  pc_sequencer #(.HALT_DRAIN(3)) dut (.CLK(clk), .nRST(nrst), .sq(sq));
`endif

  localparam logic [9:0] E_ZERO = 10'b0_00_000_00_0_0;
  localparam logic [9:0] E_SEQ  = 10'b1_00_000_00_0_0;
  localparam logic [8:0] I_IDLE = 9'b1_1_00_0_000_0;
  localparam logic [8:0] I_RST  = 9'b0_1_00_0_000_0;
  localparam logic [8:0] I_JFZ  = 9'b1_0_00_0_001_0;

  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] sb [$];

  function automatic logic [9:0] obs_vec();
    return {sq.pcEN, sq.pcSel, sq.stall_ifid, sq.stall_idex, sq.stall_exmem,
            sq.flush_ifid, sq.flush_idex, sq.redirect_pend, sq.halt};
  endfunction

  task automatic test_reset();
    logic [8:0] st [4];
    logic [9:0] ex [4];
    logic [9:0] e, o;
    st = '{I_RST, I_IDLE, I_RST, I_IDLE};
    ex = '{E_ZERO, E_SEQ, E_ZERO, E_SEQ};
    for (int i = 0; i < 4; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL reset[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_over_j();
    logic [8:0] st [2];
    logic [9:0] ex [2];
    logic [9:0] e, o;
    st = '{9'b1_1_00_0_101_0, I_IDLE};
    ex = '{10'b1_01_000_11_0_0, E_SEQ};
    for (int i = 0; i < 2; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL br_over_j[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  // J held under an icache miss (a JR shows up mid-wait and must not change
  // the latched source), then a pending J superseded by a branch.
  task automatic test_redirect_wait();
    logic [8:0] st [10];
    logic [9:0] ex [10];
    logic [9:0] e, o;
    st = '{I_JFZ, I_JFZ, 9'b1_0_00_0_010_0, I_JFZ, 9'b1_1_00_0_001_0, I_IDLE,
           I_JFZ, 9'b1_0_00_0_100_0, I_IDLE, I_IDLE};
    ex = '{10'b0_11_111_00_1_0, 10'b0_11_111_00_1_0, 10'b0_11_111_00_1_0,
           10'b0_11_111_00_1_0, 10'b1_11_000_10_1_0, E_SEQ,
           10'b0_11_111_00_1_0, 10'b0_01_111_00_1_0, 10'b1_01_000_11_1_0, E_SEQ};
    for (int i = 0; i < 10; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL redir_wait[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  // Load-use bubble, redirect beating load-use, dcache hit vs miss.
  task automatic test_lu_hazard();
    logic [8:0] st [5];
    logic [9:0] ex [5];
    logic [9:0] e, o;
    st = '{9'b1_1_00_1_000_0, I_IDLE, 9'b1_1_00_1_001_0, 9'b1_1_11_0_000_0, 9'b1_1_10_0_000_0};
    ex = '{10'b0_00_100_01_0_0, E_SEQ, 10'b1_11_000_10_0_0, E_SEQ, 10'b0_00_111_00_0_0};
    for (int i = 0; i < 5; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL lu_hazard[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_with_branch();
    logic [8:0] st [3];
    logic [9:0] ex [3];
    logic [9:0] e, o;
    st = '{9'b1_1_00_0_100_1, I_IDLE, I_IDLE};
    ex = '{10'b1_01_000_11_0_0, E_SEQ, E_SEQ};
    for (int i = 0; i < 3; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL halt_br[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  // HALT, two dcache-miss cycles inside the drain, three live drain cycles,
  // then halt; once halted every input is ignored.
  task automatic test_halt_drain();
    logic [8:0] st [9];
    logic [9:0] ex [9];
    logic [9:0] e, o;
    st = '{9'b1_1_00_0_000_1, 9'b1_1_10_0_000_0, 9'b1_1_10_0_000_0, I_IDLE, I_IDLE, I_IDLE,
           I_IDLE, 9'b1_1_00_0_101_0, 9'b1_0_00_0_000_0};
    ex = '{10'b0_00_000_10_0_0, 10'b0_00_111_00_0_0, 10'b0_00_111_00_0_0,
           10'b0_00_000_10_0_0, 10'b0_00_000_10_0_0, 10'b0_00_000_10_0_0,
           10'b0_00_000_10_0_1, 10'b0_00_000_00_0_1, 10'b0_00_000_00_0_1};
    for (int i = 0; i < 9; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL halt_drain[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  // Reset out of HALTED, mid-redirect and mid-drain: always back to plain RUN.
  task automatic test_reset_mid();
    logic [8:0] st [10];
    logic [9:0] ex [10];
    logic [9:0] e, o;
    st = '{I_RST, I_IDLE, I_JFZ, I_RST, I_IDLE, 9'b1_1_00_0_000_1, I_IDLE, I_RST, I_IDLE, I_IDLE};
    ex = '{E_ZERO, E_SEQ, 10'b0_11_111_00_1_0, E_ZERO, E_SEQ,
           10'b0_00_000_10_0_0, 10'b0_00_000_10_0_0, E_ZERO, E_SEQ, E_SEQ};
    for (int i = 0; i < 10; i++) begin
      {nrst, sq.ihit, sq.dmem_req, sq.dhit, sq.lu_hazard, sq.br_taken_ex, sq.jr_id, sq.j_id, sq.halt_id} = st[i];
      sb.push_back(ex[i]);
      @(negedge clk);
      o = obs_vec(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid[%0d]: got %b want %b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_branch_over_j();
    test_redirect_wait();
    test_lu_hazard();
    test_halt_with_branch();
    test_halt_drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller for the fetch PC register and its next-PC mux.
- Each cycle it decides whether the PC updates (pcEN) and which source it loads (pcSel).
- It also generates the pipeline-register stall/flush controls and the halt sequence.
- Sits between the hazard/cache signals and the PC; it is the only driver of pcEN and pcSel.

Parameters:
- HALT_DRAIN, 3, number of non-frozen cycles after a halt leaves ID before halt asserts (lets the HALT instruction reach WB).

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction memory returned valid data this cycle
- dmem_req  input  1  MEM stage has a load/store outstanding
- dhit  input  1  data memory access completed this cycle
- lu_hazard  input  1  load-use hazard detected in ID
- br_taken_ex  input  1  branch resolved taken in EX
- jr_id  input  1  JR decoded in ID
- j_id  input  1  J/JAL decoded in ID
- halt_id  input  1  HALT decoded in ID
- pcEN  output  1  PC register load enable
- pcSel  output  pcMux  next-PC source: PC_SEQ, PC_BR, PC_JR or PC_J
- stall_ifid, stall_idex, stall_exmem  output  1 each  hold the named pipeline register
- flush_ifid, flush_idex  output  1 each  load a bubble into the named pipeline register
- redirect_pend  output  1  redirect latched and waiting on ihit
- halt  output  1  processor halted (sticky)

Behaviour:
- Reset (nRST=0, asynchronous):
  - state=RUN; pending redirect cleared; drain counter=0.
  - Outputs: pcEN=0, pcSel=PC_SEQ, all stall/flush=0, redirect_pend=0, halt=0.
- freeze = (dmem_req & ~dhit) | ~ihit.
  - When freeze is 1: all stall_* are 1, all flush_* are 0, pcEN=0.
  - Under freeze the pipeline holds, so redirect targets stay stable.
- Redirect priority: br_taken_ex > jr_id > j_id > sequential.
  - A redirect from ID is ignored while br_taken_ex=1 (wrong path).
- FSM states: RUN, REDIR_WAIT, DRAIN, HALTED.
- RUN with no freeze:
  - br_taken_ex: pcSel=PC_BR, pcEN=1, flush_ifid=1, flush_idex=1.
  - jr_id: pcSel=PC_JR, pcEN=1, flush_ifid=1.
  - j_id: pcSel=PC_J, pcEN=1, flush_ifid=1.
  - lu_hazard (no redirect): pcEN=0, stall_ifid=1, flush_idex=1. A redirect present in the same cycle takes precedence over lu_hazard.
  - halt_id (no br_taken_ex): pcEN=0, flush_ifid=1, counter=HALT_DRAIN, next state DRAIN.
  - Otherwise: pcSel=PC_SEQ, pcEN=1.
- RUN with freeze and a redirect present:
  - Latch the chosen pcSel into the pending register; next state REDIR_WAIT.
- REDIR_WAIT:
  - redirect_pend=1; pcSel is driven from the pending register, regardless of later source changes.
  - On the first non-freeze cycle: pcEN=1, apply the flushes for the latched source, clear pending, return to RUN.
  - A br_taken_ex arriving while a J/JR is pending overwrites the pending register with PC_BR.
- DRAIN:
  - pcEN=0 and flush_ifid=1 every cycle.
  - Counter decrements only on non-freeze cycles.
  - When counter reaches 0: halt=1, next state HALTED.
- HALTED:
  - pcEN=0, halt=1 until reset; all inputs ignored.
- Reset mid-redirect or mid-drain returns to RUN with no pending redirect.

Optional Feature:
- Macro: PC_SEQUENCER_PERF_EN.
- With the macro defined, three extra output ports are added, each a 32-bit saturating counter cleared by reset:
  - stall_cycles: counts cycles with freeze=1.
  - redirect_count: counts applied redirects.
  - lu_bubbles: counts load-use bubbles.
- Without the macro: no counters and no extra ports; remaining behaviour is identical.

Decomposition:
- mux_types_pkg holds the pcMux enum (PC_SEQ, PC_BR, PC_JR, PC_J).
- cpu_types_pkg holds the pcseq_state_t enum (RUN, REDIR_WAIT, DRAIN, HALTED).
- The state/pending/counter logic stays in pc_sequencer.
- One natural sub-module, redirect_prio: combinational priority encoder from {br_taken_ex, jr_id, j_id} to pcMux plus a valid bit. Reused by the hazard unit's flush logic.
- Expose the controls through a pc_sequencer_if interface; its pcEN/pcSel outputs connect directly to the PC interface.

Test Plan:
- Reset asserted mid-cycle with ihit=1 -> pcEN=0, halt=0, pcSel=PC_SEQ immediately; after release with ihit=1 -> pcEN=1, pcSel=PC_SEQ.
- br_taken_ex=1 and j_id=1 together, ihit=1 -> pcSel=PC_BR, pcEN=1, flush_ifid=1, flush_idex=1; J ignored.
- j_id=1 with ihit=0 for 4 cycles, then ihit=1 -> redirect_pend=1 for 4 cycles with pcEN=0; 5th cycle: pcEN=1, pcSel=PC_J, flush_ifid=1.
- lu_hazard=1 for 1 cycle, no other events -> pcEN=0, stall_ifid=1, flush_idex=1; next cycle pcEN=1.
- halt_id=1, then dmem_req=1/dhit=0 for 2 cycles inside the drain -> halt rises exactly 3 non-frozen cycles later (5 cycles total); pcEN stays 0 thereafter.
- Halt with br_taken_ex=1 in the same cycle -> halt ignored, PC_BR taken; halt stays 0.
